// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : text_pkg
//  Brief    : Shared constants and state encoding for the text console writer
//  Revision : 1.0  initial release
// ============================================================================
package text_pkg;

    // Control codes recognised by the console
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Default ring size: 84 columns x 24 rows
    localparam int TRAM_N_DEFAULT = 84 * 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_CLR_ALL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/addr_wrap.sv
`default_nettype none
// ============================================================================
//  Module   : addr_wrap
//  Brief    : Combinational (a + b) mod N for operands already below N
//  Revision : 1.0  initial release
// ============================================================================
module addr_wrap
    import text_pkg::*;
#(
    parameter int ADDRW = 11,
    parameter int N     = TRAM_N_DEFAULT
) (
    input  logic [ADDRW-1:0] i_a,
    input  logic [ADDRW-1:0] i_b,
    output logic [ADDRW-1:0] o_sum
);

    localparam logic [ADDRW:0] c_N = (ADDRW+1)'(N);

    logic [ADDRW:0] w_sum;
    logic [ADDRW:0] w_diff;

    // One extra bit holds the carry; a single subtract folds the sum back into range
    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        w_diff = w_sum - c_N;
        o_sum  = (w_sum >= c_N) ? w_diff[ADDRW-1:0] : w_sum[ADDRW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module   : text_console
//  Brief    : Byte-stream console writer feeding the tram system port, with
//             cursor tracking, control codes and ring-buffer scrolling
//  Revision : 1.0  initial release
// ============================================================================
module text_console
    import text_pkg::*;
#(
    parameter int WORD      = 32,
    parameter int BYTE      = 8,
    parameter int BYTE_CNT  = 4,
    parameter int ADDRW     = 11,
    parameter int TRAM_HRES = 84,
    parameter int TRAM_VRES = 24
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic [BYTE-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD-BYTE-1:0] attr,
    output logic [BYTE_CNT-1:0]  tram_we,
    output logic [ADDRW-1:0]     tram_addr,
    output logic [WORD-1:0]      tram_din,
    output logic [ADDRW-1:0]     scroll_offs,
    output logic [6:0]           cur_col,
    output logic [4:0]           cur_row
);

    localparam int              N          = TRAM_HRES * TRAM_VRES;
    localparam logic [ADDRW-1:0] c_HRES    = ADDRW'(TRAM_HRES);
    localparam logic [ADDRW-1:0] c_N_M1    = ADDRW'(N - 1);
    localparam logic [ADDRW-1:0] c_ONE     = ADDRW'(1);
    localparam logic [6:0]       c_COL_LAST = 7'(TRAM_HRES - 1);
    localparam logic [4:0]       c_ROW_LAST = 5'(TRAM_VRES - 1);
    localparam logic [BYTE-1:0]  c_SPACE   = BYTE'(CH_SPACE);

    state_t                 r_state,       w_state_nxt;
    logic                   r_in_ready,    w_in_ready_nxt;
    logic                   r_tram_we,     w_tram_we_nxt;
    logic [ADDRW-1:0]       r_tram_addr,   w_tram_addr_nxt;
    logic [WORD-1:0]        r_tram_din,    w_tram_din_nxt;
    logic [ADDRW-1:0]       r_scroll_offs, w_scroll_offs_nxt;
    logic [ADDRW-1:0]       r_line_base,   w_line_base_nxt;
    logic [6:0]             r_cur_col,     w_cur_col_nxt;
    logic [4:0]             r_cur_row,     w_cur_row_nxt;
    logic [ADDRW-1:0]       r_clr_addr,    w_clr_addr_nxt;
    logic [ADDRW-1:0]       r_clr_cnt,     w_clr_cnt_nxt;
    logic [WORD-BYTE-1:0]   r_clr_attr,    w_clr_attr_nxt;

    logic                   w_accept;
    logic                   w_nl;
    logic                   w_nl_print;
    logic [ADDRW-1:0]       w_wr_addr;
    logic [ADDRW-1:0]       w_lb_step;
    logic [ADDRW-1:0]       w_so_step;
    logic [ADDRW-1:0]       w_inc_base;
    logic [ADDRW-1:0]       w_inc;

    assign w_accept   = in_valid && r_in_ready;
    // In IDLE the incrementer seeds the line clear from the old scroll base
    assign w_inc_base = (r_state == ST_IDLE) ? r_scroll_offs : r_clr_addr;

    addr_wrap #(.ADDRW(ADDRW), .N(N)) u_wr_addr (
        .i_a(r_line_base), .i_b(ADDRW'(r_cur_col)), .o_sum(w_wr_addr));
    addr_wrap #(.ADDRW(ADDRW), .N(N)) u_lb_step (
        .i_a(r_line_base), .i_b(c_HRES), .o_sum(w_lb_step));
    addr_wrap #(.ADDRW(ADDRW), .N(N)) u_so_step (
        .i_a(r_scroll_offs), .i_b(c_HRES), .o_sum(w_so_step));
    addr_wrap #(.ADDRW(ADDRW), .N(N)) u_inc (
        .i_a(w_inc_base), .i_b(c_ONE), .o_sum(w_inc));

    // Byte decode, newline/scroll handling and clear sequencing
    always_comb begin
        w_state_nxt       = r_state;
        w_in_ready_nxt    = 1'b0;
        w_tram_we_nxt     = 1'b0;
        w_tram_addr_nxt   = r_tram_addr;
        w_tram_din_nxt    = r_tram_din;
        w_scroll_offs_nxt = r_scroll_offs;
        w_line_base_nxt   = r_line_base;
        w_cur_col_nxt     = r_cur_col;
        w_cur_row_nxt     = r_cur_row;
        w_clr_addr_nxt    = r_clr_addr;
        w_clr_cnt_nxt     = r_clr_cnt;
        w_clr_attr_nxt    = r_clr_attr;
        w_nl              = 1'b0;
        w_nl_print        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (in_data >= c_SPACE) begin
                        w_tram_we_nxt   = 1'b1;
                        w_tram_addr_nxt = w_wr_addr;
                        w_tram_din_nxt  = {attr, in_data};
                        if (r_cur_col == c_COL_LAST) begin
                            w_cur_col_nxt = 7'd0;
                            w_nl          = 1'b1;
                            w_nl_print    = 1'b1;
                        end else begin
                            w_cur_col_nxt = r_cur_col + 7'd1;
                        end
                    end else if (in_data == BYTE'(CH_LF)) begin
                        w_cur_col_nxt = 7'd0;
                        w_nl          = 1'b1;
                    end else if (in_data == BYTE'(CH_CR)) begin
                        w_cur_col_nxt = 7'd0;
                    end else if (in_data == BYTE'(CH_BS)) begin
                        if (r_cur_col != 7'd0) begin
                            w_cur_col_nxt = r_cur_col - 7'd1;
                        end
                    end else if (in_data == BYTE'(CH_FF)) begin
                        // First clear word goes out immediately; the rest follow from address 1
                        w_tram_we_nxt     = 1'b1;
                        w_tram_addr_nxt   = '0;
                        w_tram_din_nxt    = {attr, c_SPACE};
                        w_clr_addr_nxt    = c_ONE;
                        w_clr_cnt_nxt     = c_N_M1;
                        w_clr_attr_nxt    = attr;
                        w_scroll_offs_nxt = '0;
                        w_line_base_nxt   = '0;
                        w_cur_col_nxt     = 7'd0;
                        w_cur_row_nxt     = 5'd0;
                        w_in_ready_nxt    = 1'b0;
                        w_state_nxt       = ST_CLR_ALL;
                    end
                end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
                if (r_clr_cnt != '0) begin
                    w_tram_we_nxt   = 1'b1;
                    w_tram_addr_nxt = r_clr_addr;
                    w_tram_din_nxt  = {r_clr_attr, c_SPACE};
                    w_clr_addr_nxt  = w_inc;
                    w_clr_cnt_nxt   = r_clr_cnt - c_ONE;
                end else begin
                    w_in_ready_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A newline always advances line_base by one row; at the bottom it scrolls instead
        if (w_nl) begin
            w_line_base_nxt = w_lb_step;
            if (r_cur_row != c_ROW_LAST) begin
                w_cur_row_nxt = r_cur_row + 5'd1;
            end else begin
                w_scroll_offs_nxt = w_so_step;
                w_clr_attr_nxt    = attr;
                w_in_ready_nxt    = 1'b0;
                w_state_nxt       = ST_CLR_LINE;
                if (w_nl_print) begin
                    // The glyph occupies this cycle's write slot; the clear starts next cycle
                    w_clr_addr_nxt = r_scroll_offs;
                    w_clr_cnt_nxt  = c_HRES;
                end else begin
                    w_tram_we_nxt   = 1'b1;
                    w_tram_addr_nxt = r_scroll_offs;
                    w_tram_din_nxt  = {attr, c_SPACE};
                    w_clr_addr_nxt  = w_inc;
                    w_clr_cnt_nxt   = c_HRES - c_ONE;
                end
            end
        end
    end

    // State and output registers; reset drops everything except tram contents
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b0;
            r_tram_we     <= 1'b0;
            r_tram_addr   <= '0;
            r_tram_din    <= '0;
            r_scroll_offs <= '0;
            r_line_base   <= '0;
            r_cur_col     <= 7'd0;
            r_cur_row     <= 5'd0;
            r_clr_addr    <= '0;
            r_clr_cnt     <= '0;
            r_clr_attr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_tram_we     <= w_tram_we_nxt;
            r_tram_addr   <= w_tram_addr_nxt;
            r_tram_din    <= w_tram_din_nxt;
            r_scroll_offs <= w_scroll_offs_nxt;
            r_line_base   <= w_line_base_nxt;
            r_cur_col     <= w_cur_col_nxt;
            r_cur_row     <= w_cur_row_nxt;
            r_clr_addr    <= w_clr_addr_nxt;
            r_clr_cnt     <= w_clr_cnt_nxt;
            r_clr_attr    <= w_clr_attr_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign tram_we     = {BYTE_CNT{r_tram_we}};
    assign tram_addr   = r_tram_addr;
    assign tram_din    = r_tram_din;
    assign scroll_offs = r_scroll_offs;
    assign cur_col     = r_cur_col;
    assign cur_row     = r_cur_row;

endmodule
`default_nettype wire

// File: doc/text_console.md
# text_console

Character-stream writer that sits directly upstream of the text-mode RAM system port (`we_sys`/`addr_sys`/`din_sys`) and drives the scroll offset consumed by `textmode`.
- Accepts one byte per cycle over a valid/ready handshake and keeps a cursor.
- Interprets a small set of control codes.
- Writes glyph words into tram.
- Scrolls by advancing a ring-buffer offset and clearing the newly exposed line.

## Interface
Parameters:
- `WORD`, 32: tram word width (bits)
- `BYTE`, 8: glyph code width (bits)
- `BYTE_CNT`, 4: tram write-enable lanes (`WORD/BYTE`)
- `ADDRW`, 11: tram address width; `2**ADDRW >= TRAM_HRES*TRAM_VRES` is required
- `TRAM_HRES`, 84: text columns
- `TRAM_VRES`, 24: text rows

Ports (one clock; reset is synchronous and active-high):
- `clk_sys` in 1: system clock
- `rst_sys` in 1: synchronous active-high reset
- `in_data` in `BYTE`: character code
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: block can accept; transfer occurs when `in_valid && in_ready`
- `attr` in `WORD-BYTE`: attribute bits, sampled at accept, forming the upper word bits
- `tram_we` out `BYTE_CNT`: tram write enable, either all ones or all zeros
- `tram_addr` out `ADDRW`: tram word address
- `tram_din` out `WORD`: tram write data `{attr, glyph}`
- `scroll_offs` out `ADDRW`: word index of the top-left visible character
- `cur_col` out 7: cursor column, 0..`TRAM_HRES-1`
- `cur_row` out 5: cursor row, 0..`TRAM_VRES-1`

## Operation
- Define N = `TRAM_HRES*TRAM_VRES` (2016). All tram addresses wrap modulo N; `textmode` reads with the same wrap.
- Internal `line_base` = (`scroll_offs` + `cur_row*TRAM_HRES`) mod N. It is updated incrementally and no multiplier is used.
- Write address for a character = (`line_base` + `cur_col`) mod N.
- All mod-N sums are computed at `ADDRW+1` bits with a single compare/subtract.
- Decoding of an accepted byte:
  - 0x20–0xFF (printable):
    - Write `{attr, in_data}` at the cursor, then `cur_col+1`.
    - At column `HRES-1`: `cur_col`→0 and a newline is performed.
  - 0x0A (LF): `cur_col`→0, then newline.
  - 0x0D (CR): `cur_col`→0.
  - 0x08 (BS): `cur_col-1` if `cur_col>0`, else no-op. No write.
  - 0x0C (FF): clear all N words to `{attr, 8'h20}`. Cursor moves home and `scroll_offs`→0.
  - All other codes below 0x20: ignored, with no write and no cursor change.
- Newline:
  - If `cur_row<VRES-1`: `cur_row+1`.
  - Otherwise scroll: `scroll_offs` ← (`scroll_offs+HRES`) mod N, `cur_row` is unchanged, and the new bottom line (old `scroll_offs` base) is cleared to `{attr, 8'h20}`.
- FSM states:
  - IDLE (`in_ready=1`):
    - Scroll → CLR_LINE.
    - FF → CLR_ALL.
    - Otherwise stays in IDLE.
  - CLR_LINE: issues `HRES` sequential writes, then → IDLE.
  - CLR_ALL: issues N writes at addresses 0..N-1, then → IDLE.
  - `in_ready=0` outside IDLE.
- Reset:
  - Forces IDLE.
  - All outputs reset to 0, including `in_ready=0` while `rst_sys` is high; `in_ready` goes to 1 in the first cycle after release.
  - Tram contents are not cleared, so preloaded text survives.
  - Reset asserted mid-clear aborts at once: `tram_we=0` from the next cycle and partial contents remain.

## Timing
- All outputs are registered.
- Printable byte accepted at cycle t:
  - `tram_we`/`tram_addr`/`tram_din` valid for exactly one cycle at t+1.
  - `cur_col`/`cur_row` update at t+1.
  - Throughput is one character per cycle.
- LF causing scroll, accepted at t:
  - `scroll_offs` updates at t+1.
  - Clear writes occur at t+1..t+HRES (84 cycles), at ascending addresses with mod-N wrap.
  - `in_ready` is low t+1..t+HRES and high at t+HRES+1.
- Printable byte at bottom-right, accepted at t:
  - Character written at t+1.
  - `scroll_offs` updates at t+1.
  - Clear writes occur at t+2..t+HRES+1.
  - `in_ready` is low t+1..t+HRES+1.
- FF accepted at t:
  - Writes occur at t+1..t+N.
  - `scroll_offs`=0 and cursor home at t+1.
  - `in_ready` is high again at t+N+1.
- `in_valid` held high while `in_ready` is low: no byte is consumed, and `in_data` must be held stable by the source.

## Structure
- Shared package `text_pkg` holds:
  - control-code constants (`CH_BS`, `CH_LF`, `CH_FF`, `CH_CR`, `CH_SPACE`)
  - FSM state encoding
  - the default N
- One sub-module: `addr_wrap`, a combinational (a+b) mod N adder used for `line_base`, the write address and `scroll_offs`.

## Test plan
- After reset, send "AB": writes `{attr,0x41}` @0 and `{attr,0x42}` @1 on consecutive cycles; cursor ends at (2,0).
- Send 84 × 'x' from home: last write @83; cursor ends at (0,1) with no clear.
- Place cursor at row 23 and send LF:
  - `scroll_offs`=84.
  - 84 writes of `{attr,0x20}` @0..83.
  - `in_ready` low for exactly 84 cycles.
- Repeat scrolling 24 times:
  - `scroll_offs` wraps 1932→0.
  - The clear of the bottom line at base 1932 writes 1932..2015.
  - Write addresses never reach ≥2016.
- Send BS at col 0 and CR mid-line: no writes; cursor is (0,row) in both cases.
- Send FF, then assert `rst_sys` at write 500:
  - `tram_we`=0 next cycle.
  - All outputs 0.
  - `in_ready`=1 one cycle after release.
